stat_display_driver: RTL and testbench

- Consumes the three 32-bit cycle-statistics counters (total, taken conditional branch, unconditional jump) and shows one of them on the board's 8-digit multiplexed seven-segment display.
- Continuously samples the selected counter and converts it to BCD with a sequential double-dabble engine, or shows it as raw hex.
- Drives the display with a time-multiplexed digit scan.
- Sits directly downstream of the cycle-statistics counter block, at the top level next to the CPU.

---
 rtl/stat_display_driver.sv | 155 +++++++++++++++
 tb/tb_stat_display_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_display_driver.sv
// Shows one of four 32-bit statistics values on an 8-digit multiplexed seven-segment display.
// A double-dabble engine re-converts the selected value back-to-back; raw hex skips the conversion.
module stat_display_driver #(
  parameter int SCAN_DIV = 1024,
  parameter int SCAN_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] total_cycle,
  input  logic [31:0] co_branch_cycle,
  input  logic [31:0] un_branch_cycle,
  input  logic [31:0] aux_value,
  input  logic [1:0]  sel,
  input  logic        hex_mode,
  output logic        busy,
  output logic        overflow,
  output logic [31:0] digits_out,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic        mode_q, mode_d;
  logic [39:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] digits_q, digits_d;
  logic        ovf_q, ovf_d;
  logic [31:0] src;

  logic [SCAN_W-1:0] presc_q;
  logic [2:0]        idx_q, idx_nx;
  logic [7:0]        an_q, seg_q, enc_nx;

  // Double-dabble correction: any BCD digit of 5 or more would overflow on the next shift.
  function automatic logic [39:0] dd_adjust(input logic [39:0] a);
    logic [39:0] r;
    r = a;
    for (int i = 0; i < 10; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    case (d)
      4'h0: seg_encode = 8'hC0;
      4'h1: seg_encode = 8'hF9;
      4'h2: seg_encode = 8'hA4;
      4'h3: seg_encode = 8'hB0;
      4'h4: seg_encode = 8'h99;
      4'h5: seg_encode = 8'h92;
      4'h6: seg_encode = 8'h82;
      4'h7: seg_encode = 8'hF8;
      4'h8: seg_encode = 8'h80;
      4'h9: seg_encode = 8'h90;
      4'hA: seg_encode = 8'h88;
      4'hB: seg_encode = 8'h83;
      4'hC: seg_encode = 8'hC6;
      4'hD: seg_encode = 8'hA1;
      4'hE: seg_encode = 8'h86;
      default: seg_encode = 8'h8E;
    endcase
  endfunction

  always_comb begin
    case (sel)
      2'd0:    src = total_cycle;
      2'd1:    src = co_branch_cycle;
      2'd2:    src = un_branch_cycle;
      default: src = aux_value;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
    end
  end

  // Conversion datapath needs no reset: IDLE reloads all of it before use.
  always_ff @(posedge clk) begin
    value_q <= value_d;
    mode_q  <= mode_d;
    acc_q   <= acc_d;
    cnt_q   <= cnt_d;
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        value_d = src;
        mode_d  = hex_mode;
        acc_d   = '0;
        cnt_d   = 5'd31;
        state_d = hex_mode ? DONE : SHIFT;
      end
      SHIFT: begin
        {acc_d, value_d} = {dd_adjust(acc_q), value_q} << 1;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = DONE;
      end
      DONE: begin
        digits_d = mode_q ? value_q : acc_q[31:0];
        ovf_d    = !mode_q && (acc_q[39:32] != 8'd0);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign idx_nx = idx_q + 3'd1;
  assign enc_nx = seg_encode(digits_q[{idx_nx, 2'b00} +: 4]);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
    end else if (presc_q == SCAN_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= idx_nx;
      an_q    <= ~(8'b1 << idx_nx);
      seg_q   <= {~((idx_nx == 3'd7) && ovf_q), enc_nx[6:0]};
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign overflow   = ovf_q;
  assign digits_out = digits_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_stat_display_driver.sv
// Randomized scoreboard bench for stat_display_driver with a small scan divider.
module tb_stat_display_driver;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] total_cycle = '0, co_branch_cycle = '0, un_branch_cycle = '0, aux_value = '0;
  logic [1:0]  sel = '0;
  logic        hex_mode = 1'b0;
  logic        busy, overflow;
  logic [31:0] digits_out;
  logic [7:0]  an, seg;

  stat_display_driver #(.SCAN_DIV(SD), .SCAN_W(2)) dut (
    .clk(clk), .rst(rst),
    .total_cycle(total_cycle), .co_branch_cycle(co_branch_cycle),
    .un_branch_cycle(un_branch_cycle), .aux_value(aux_value),
    .sel(sel), .hex_mode(hex_mode),
    .busy(busy), .overflow(overflow), .digits_out(digits_out),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dig;
    logic        ovf;
    logic        hex;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0, nerr = 0, nres = 0;
  logic [31:0] disp_m = '0;
  logic        ovf_m = 1'b0;
  logic [7:0]  exp_an = 8'hFF, exp_seg = 8'hFF;
  logic        scan_ok = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] t[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[d];
  endfunction

  // Reference: decimal shows the low 8 decimal digits, overflow when the value needs more.
  function automatic exp_t model(input logic [31:0] v, input logic hx);
    exp_t r;
    longint unsigned x;
    x     = 64'(v);
    r.hex = hx;
    r.dig = '0;
    r.ovf = 1'b0;
    if (hx) r.dig = v;
    else begin
      r.ovf = (x > 64'd99999999);
      for (int i = 0; i < 8; i++) begin
        r.dig[i*4 +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] cur_src();
    case (sel)
      2'd0: return total_cycle;
      2'd1: return co_branch_cycle;
      2'd2: return un_branch_cycle;
      default: return aux_value;
    endcase
  endfunction

  task automatic push_current();
    q.push_back(model(cur_src(), hex_mode));
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp[6] = '{32'd0, 32'd99999999, 32'd100000000, 32'hFFFFFFFF, 32'd12345678, 32'hDEADBEEF};
    case ($urandom_range(0, 3))
      0:       return sp[$urandom_range(0, 5)];
      1:       return 32'($urandom_range(0, 99999));
      default: return $urandom;
    endcase
  endfunction

  task automatic randomize_inputs();
    total_cycle     = pick();
    co_branch_cycle = pick();
    un_branch_cycle = pick();
    aux_value       = pick();
    sel             = 2'($urandom_range(0, 3));
    hex_mode        = ($urandom_range(0, 2) == 0);
  endtask

  task automatic wait_done(output int n);
    int start;
    start = nres;
    n = 0;
    while (nres == start && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (nres == start) begin
      nvec++;
      nerr++;
      $display("FAIL result_timeout: no result after %0d cycles, expected one within 34", n);
    end
  endtask

  // Scan reference: edges since reset release decide which digit is lit.
  initial begin
    int e, idx;
    e = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        e = 0; exp_an = 8'hFF; exp_seg = 8'hFF; disp_m = '0; ovf_m = 1'b0; scan_ok = 1'b1;
      end else begin
        e++;
        if (e % SD == 0) begin
          idx     = (e / SD) % 8;
          exp_an  = ~(8'b1 << idx);
          exp_seg = enc(disp_m[idx*4 +: 4]);
          if (idx == 7 && ovf_m) exp_seg[7] = 1'b0;
        end
      end
    end
  end

  // Monitor: a falling busy marks a freshly written result.
  initial begin
    logic bprev;
    int   bcnt;
    exp_t ex;
    bprev = 1'b0;
    bcnt  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bprev = 1'b0;
        bcnt  = 0;
        continue;
      end
      if (busy === 1'b1) bcnt++;
      else if (bprev) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL scoreboard: result %0h appeared with nothing expected", digits_out);
        end else begin
          ex = q.pop_front();
          chk("digits_out", 64'(digits_out), 64'(ex.dig));
          chk("overflow", 64'(overflow), 64'(ex.ovf));
          chk("busy_cycles", 64'(bcnt), ex.hex ? 64'd1 : 64'd33);
          disp_m = ex.dig;
          ovf_m  = ex.ovf;
        end
        bcnt = 0;
        nres++;
      end
      bprev = busy;
      if (scan_ok) begin
        chk("an", 64'(an), 64'(exp_an));
        chk("seg", 64'(seg), 64'(exp_seg));
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_digits", 64'(digits_out), 64'd0);
    chk("rst_an", 64'(an), 64'hFF);
    chk("rst_seg", 64'(seg), 64'hFF);

    // decimal conversion straight out of reset
    total_cycle = 32'd12345678; sel = 2'd0; hex_mode = 1'b0;
    push_current();
    rst = 1'b0;
    wait_done(n);
    chk("first_latency", 64'(n), 64'd34);

    // overflow with dp on the leftmost digit
    aux_value = 32'hFFFFFFFF; sel = 2'd3;
    push_current();
    wait_done(n);
    repeat (2) begin push_current(); wait_done(n); end

    // hex display
    un_branch_cycle = 32'hDEADBEEF; sel = 2'd2; hex_mode = 1'b1;
    push_current();
    wait_done(n);
    chk("hex_latency", 64'(n), 64'd2);
    repeat (20) begin push_current(); wait_done(n); end

    // mid-conversion source change only lands on the following capture
    total_cycle = 32'd5; co_branch_cycle = 32'd7; sel = 2'd0; hex_mode = 1'b0;
    push_current();
    repeat (10) @(negedge clk);
    sel = 2'd1;
    wait_done(n);
    push_current();
    wait_done(n);

    // reset during SHIFT abandons the conversion
    total_cycle = 32'd8; sel = 2'd0;
    push_current();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_digits", 64'(digits_out), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    chk("midrst_an", 64'(an), 64'hFF);
    chk("midrst_seg", 64'(seg), 64'hFF);
    q.delete();
    @(negedge clk);
    push_current();
    rst = 1'b0;
    wait_done(n);
    chk("post_rst_latency", 64'(n), 64'd34);
    repeat (3) begin push_current(); wait_done(n); end

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) != 0) randomize_inputs();
      push_current();
      if (!hex_mode && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(2, 30)) @(negedge clk);
        randomize_inputs();
      end
      wait_done(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
